// File: rtl/multicycle_control.sv
// multicycle_control: multicycle CPU control FSM with memory handshake, timeout fault and retire counter
module multicycle_control #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_mem_write,
  input  logic        dec_reg_write,
  input  logic        dec_mem_to_reg,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        dec_jump_reg,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write_en,
  output logic [1:0]  wb_sel,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retired
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, FAULT = 3'd5} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] retired_q, retired_d;
  logic        waiting, timeout, retire, to_mem;
  assign state   = state_q;
  assign retired = retired_q;
  // next state, wait counter, retire count and strobes; strobes held low while in reset
  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    addr_sel     = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    reg_write_en = 1'b0;
    wb_sel       = 2'd0;
    fault        = 1'b0;
    retire       = 1'b0;
    to_mem       = dec_mem_write || dec_mem_to_reg;
    waiting      = (state_q == FETCH || state_q == MEM) && !mem_ready;
    timeout      = waiting && wait_q == WAIT_LAST;
    wait_d       = waiting ? wait_q + 8'd1 : 8'd0;
    case (state_q)
      FETCH: begin
        mem_req  = rst_n;
        ir_write = rst_n && mem_ready;
        state_d  = mem_ready ? DECODE : timeout ? FAULT : FETCH;
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        pc_write = rst_n;
        pc_src   = dec_jump_reg ? 2'd3 : dec_jump ? 2'd2 : (dec_branch && alu_zero) ? 2'd1 : 2'd0;
        state_d  = to_mem ? MEM : dec_reg_write ? WB : FETCH;
        retire   = !to_mem && !dec_reg_write;
      end
      MEM: begin
        mem_req  = rst_n;
        addr_sel = rst_n;
        mem_we   = rst_n && dec_mem_write;
        state_d  = mem_ready ? (dec_mem_to_reg ? WB : FETCH) : timeout ? FAULT : MEM;
        retire   = mem_ready && !dec_mem_to_reg;
      end
      WB: begin
        reg_write_en = rst_n;
        wb_sel       = !rst_n ? 2'd0 : dec_mem_to_reg ? 2'd1 : (dec_jump || dec_jump_reg) ? 2'd2 : 2'd0;
        state_d      = FETCH;
        retire       = 1'b1;
      end
      FAULT: fault = rst_n;
      default: state_d = FETCH;
    endcase
    retired_d = retired_q + {31'd0, retire};
  end
  // state, wait counter and retire counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      wait_q    <= 8'd0;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, max consecutive wait cycles per memory request before fault (valid range 1..255).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 dec_mem_write, dec_reg_write, dec_mem_to_reg, dec_branch, dec_jump, dec_jump_reg  input  1 each  decoder control outputs for the instruction held in IR.
REQ-005 alu_zero  input  1  ALU zero flag (branch condition).
REQ-006 mem_ready  input  1  memory completes the current request this cycle.
REQ-007 mem_req  output  1  memory request, held until mem_ready.
REQ-008 mem_we  output  1  request is a write.
REQ-009 addr_sel  output  1  memory address source: 0 = PC, 1 = ALU result.
REQ-010 ir_write  output  1  latch read data into IR.
REQ-011 pc_write  output  1  update PC.
REQ-012 pc_src  output  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = ALU result (jalr).
REQ-013 reg_write_en  output  1  register file write strobe.
REQ-014 wb_sel  output  2  0 = ALU, 1 = memory data, 2 = link (PC+4).
REQ-015 fault  output  1  sticky memory-timeout fault.
REQ-016 state  output  3  current FSM state encoding.
REQ-017 retired  output  32  count of completed instructions.

Function
REQ-018 States/encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5; values 6-7 shall go to FETCH next cycle.
REQ-019 All outputs Moore/Mealy-combinational from state and inputs as listed; unlisted strobes are 0 in every state.
REQ-020 FETCH: mem_req=1, mem_we=0, addr_sel=0; on mem_ready: ir_write=1 same cycle, next DECODE; else stay.
REQ-021 DECODE: no strobes, one cycle, next EXEC.
REQ-022 EXEC: pc_write=1; pc_src=3 if dec_jump_reg, else 2 if dec_jump, else 1 if dec_branch && alu_zero, else 0.
REQ-023 EXEC next: MEM if dec_mem_write or dec_mem_to_reg; else WB if dec_reg_write; else FETCH (retire).
REQ-024 MEM: mem_req=1, addr_sel=1, mem_we=dec_mem_write; wait for mem_ready; then WB if dec_mem_to_reg, else FETCH (retire).
REQ-025 WB: reg_write_en=1 for exactly one cycle; wb_sel=1 if dec_mem_to_reg, 2 if dec_jump or dec_jump_reg, else 0; next FETCH (retire).
REQ-026 Latency: ALU op 4 cycles, store 4 + waits, load 5 + waits, branch/non-writing op 3 cycles + fetch waits.
REQ-027 retired increments by 1 on every retiring transition into FETCH; wraps 0xFFFFFFFF -> 0.
REQ-028 Wait counter: 8-bit, cleared on each new request and on mem_ready; increments each FETCH/MEM cycle with mem_ready=0.
REQ-029 When the wait counter reaches MEM_TIMEOUT with mem_ready=0, next state FAULT; mem_ready in that same cycle wins (normal completion).
REQ-030 FAULT: fault=1, all strobes 0, state held until reset.
REQ-031 mem_ready in DECODE, EXEC, WB or FAULT shall be ignored.

Reset
REQ-032 rst_n=0 at a clock edge: state=FETCH, retired=0, wait counter=0, fault=0; applies mid-request, memory request is abandoned.
REQ-033 During reset cycles outputs take FETCH values with ir_write=0 (mem_req=1 only after rst_n=1).

Verification
REQ-034 ALU op (dec_reg_write=1), mem_ready=1 in FETCH -> states 0,1,2,4,0; pc_write in EXEC with pc_src=0; reg_write_en one cycle, wb_sel=0; retired=1.
REQ-035 Load with 2 wait cycles in MEM -> mem_req held 3 cycles, addr_sel=1, mem_we=0, then WB with wb_sel=1; total 7 cycles.
REQ-036 Store -> MEM with mem_we=1, then FETCH, no reg_write_en; branch with alu_zero=1 -> pc_src=1, alu_zero=0 -> pc_src=0.
REQ-037 jal (dec_jump=1, dec_reg_write=1) -> pc_src=2, wb_sel=2; jalr -> pc_src=3.
REQ-038 MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> FAULT after 4 wait cycles, fault=1 sticky; mem_ready on 4th cycle -> no fault.
REQ-039 rst_n=0 during MEM wait with retired=5 -> next cycle state=0, retired=0, fault=0.
